// File: rtl/branch_pkg.sv
// Shared definitions for the branch resolve FIFO slice.
// Holds the default address width, the queue entry layout, the resolve
// handshake state encoding and the statistics counter width/helper.
package branch_pkg;

   localparam int unsigned BR_ADDR_W = 11;
   localparam int unsigned BR_STAT_W = 16;

   // One predicted branch awaiting resolution
   typedef struct packed {
      logic [BR_ADDR_W-1:0] addr;
      logic                 pred;
   } br_entry_t;

   // Resolve/update handshake towards the BHT
   typedef enum logic [1:0] {
      BR_IDLE   = 2'd0,
      BR_SETUP  = 2'd1,
      BR_STROBE = 2'd2
   } br_state_e;

   // Saturating increment for the statistics counters
   function automatic logic [BR_STAT_W-1:0] br_sat_inc(input logic [BR_STAT_W-1:0] v);
      return (v == '1) ? v : v + BR_STAT_W'(1);
   endfunction

endpackage

// File: rtl/branch_fifo_ram.sv
// Entry storage for the branch resolve FIFO.
// Ports: clock; we/waddr/wdata single synchronous write port;
//        raddr/rdata asynchronous read port (driven with the head pointer).
module branch_fifo_ram #(
   parameter int unsigned DEPTH = 8,
   parameter int unsigned WIDTH = 12
) (
   input  logic                     clock,
   input  logic                     we,
   input  logic [$clog2(DEPTH)-1:0] waddr,
   input  logic [WIDTH-1:0]         wdata,
   input  logic [$clog2(DEPTH)-1:0] raddr,
   output logic [WIDTH-1:0]         rdata
);

   logic [WIDTH-1:0] mem [DEPTH];

   // Storage needs no reset: an entry is only read after it was written
   always_ff @(posedge clock) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/branch_resolve_fifo.sv
// In-order buffer of predicted branches awaiting resolution, feeding the
// BHT update port with a registered address/result and a strobe that rises
// one full cycle after the address/result settle.
// Ports:
//   clock, reset (async, active-high)
//   push/push_addr/push_pred           : record a predicted branch
//   full/empty/count                   : occupancy
//   resolve_valid/resolve_taken        : in-order outcome of the head branch
//   resolve_ready                      : resolution can be accepted
//   fifo_branch_addr/branch_result     : BHT update address / outcome
//   update_strobe                      : BHT update clock, one cycle wide
//   mispredict                         : one-cycle pulse during SETUP
//   overflow/underflow                 : sticky error flags
// Optional build macro BRANCH_RESOLVE_STATS_EN adds stat_resolved and
// stat_mispredicted saturating counters.
module branch_resolve_fifo
   import branch_pkg::*;
#(
   parameter int unsigned DEPTH  = 8,
   parameter int unsigned ADDR_W = BR_ADDR_W
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic                       push,
   input  logic [ADDR_W-1:0]          push_addr,
   input  logic                       push_pred,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH):0]     count,
   input  logic                       resolve_valid,
   input  logic                       resolve_taken,
   output logic                       resolve_ready,
   output logic [ADDR_W-1:0]          fifo_branch_addr,
   output logic                       branch_result,
   output logic                       update_strobe,
   output logic                       mispredict,
   output logic                       overflow,
   output logic                       underflow
`ifdef BRANCH_RESOLVE_STATS_EN
   ,
   output logic [BR_STAT_W-1:0]       stat_resolved,
   output logic [BR_STAT_W-1:0]       stat_mispredicted
`endif
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic              pred;
   } entry_t;

   logic [PTR_W-1:0] head_q;
   logic [PTR_W-1:0] tail_q;
   logic [CNT_W-1:0] count_nx;
   entry_t           head_entry;
   entry_t           push_entry;
   br_state_e        state_q;

   logic accept_c;
   logic pop_c;
   logic mispred_c;
   logic push_ok_c;

   // Accept/pop/flush decisions for this edge
   always_comb begin
      accept_c  = resolve_valid & resolve_ready;
      pop_c     = accept_c & ~empty;
      mispred_c = pop_c & (head_entry.pred ^ resolve_taken);
      // A full queue still takes a push when the head leaves the same edge;
      // a flushing resolve discards the push outright
      push_ok_c = push & (~full | pop_c) & ~mispred_c;
   end

   always_comb begin
      push_entry.addr = push_addr;
      push_entry.pred = push_pred;
   end

   branch_fifo_ram #(
      .DEPTH (DEPTH),
      .WIDTH (ADDR_W + 1)
   ) u_ram (
      .clock (clock),
      .we    (push_ok_c),
      .waddr (tail_q),
      .wdata (push_entry),
      .raddr (head_q),
      .rdata (head_entry)
   );

   // Next occupancy
   always_comb begin
      count_nx = count;
      if (mispred_c) begin
         count_nx = '0;
      end else if (push_ok_c && !pop_c) begin
         count_nx = count + CNT_W'(1);
      end else if (!push_ok_c && pop_c) begin
         count_nx = count - CNT_W'(1);
      end
   end

   // Pointers, occupancy flags and sticky errors
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         head_q    <= '0;
         tail_q    <= '0;
         count     <= '0;
         full      <= 1'b0;
         empty     <= 1'b1;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         if (mispred_c) begin
            head_q <= '0;
            tail_q <= '0;
         end else begin
            if (pop_c)     head_q <= head_q + PTR_W'(1);
            if (push_ok_c) tail_q <= tail_q + PTR_W'(1);
         end
         count <= count_nx;
         full  <= (count_nx == CNT_W'(DEPTH));
         empty <= (count_nx == '0);
         if (push && full && !pop_c) overflow <= 1'b1;
         if (accept_c && empty)      underflow <= 1'b1;
      end
   end

   // BHT update handshake: SETUP holds addr/result one cycle before STROBE
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q          <= BR_IDLE;
         resolve_ready    <= 1'b1;
         update_strobe    <= 1'b0;
         mispredict       <= 1'b0;
         fifo_branch_addr <= '0;
         branch_result    <= 1'b0;
      end else begin
         case (state_q)
            BR_IDLE: begin
               if (pop_c) begin
                  fifo_branch_addr <= head_entry.addr;
                  branch_result    <= resolve_taken;
                  mispredict       <= mispred_c;
                  resolve_ready    <= 1'b0;
                  state_q          <= BR_SETUP;
               end
            end
            BR_SETUP: begin
               mispredict    <= 1'b0;
               update_strobe <= 1'b1;
               state_q       <= BR_STROBE;
            end
            BR_STROBE: begin
               update_strobe <= 1'b0;
               resolve_ready <= 1'b1;
               state_q       <= BR_IDLE;
            end
            default: begin
               mispredict    <= 1'b0;
               update_strobe <= 1'b0;
               resolve_ready <= 1'b1;
               state_q       <= BR_IDLE;
            end
         endcase
      end
   end

`ifdef BRANCH_RESOLVE_STATS_EN
   // Resolution statistics, saturating
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         stat_resolved     <= '0;
         stat_mispredicted <= '0;
      end else if (pop_c) begin
         stat_resolved <= br_sat_inc(stat_resolved);
         if (mispred_c) begin
            stat_mispredicted <= br_sat_inc(stat_mispredicted);
         end
      end
   end
`endif

endmodule

// File: tb/tb_branch_resolve_fifo.sv
// Self-checking bench for branch_resolve_fifo: directed scenarios with
// literal expectations plus randomized traffic against a queue-based model.
module tb_branch_resolve_fifo;
   import branch_pkg::*;

   localparam int unsigned DEPTH  = 8;
   localparam int unsigned ADDR_W = BR_ADDR_W;
   localparam int unsigned CNT_W  = $clog2(DEPTH) + 1;

   logic              clock = 1'b0;
   logic              reset;
   logic              push;
   logic [ADDR_W-1:0] push_addr;
   logic              push_pred;
   logic              full, empty;
   logic [CNT_W-1:0]  count;
   logic              resolve_valid, resolve_taken, resolve_ready;
   logic [ADDR_W-1:0] fifo_branch_addr;
   logic              branch_result, update_strobe, mispredict;
   logic              overflow, underflow;
`ifdef BRANCH_RESOLVE_STATS_EN
   logic [BR_STAT_W-1:0] stat_resolved, stat_mispredicted;
   int                   m_sres, m_smis;
`endif

   branch_resolve_fifo #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
      .clock            (clock),
      .reset            (reset),
      .push             (push),
      .push_addr        (push_addr),
      .push_pred        (push_pred),
      .full             (full),
      .empty            (empty),
      .count            (count),
      .resolve_valid    (resolve_valid),
      .resolve_taken    (resolve_taken),
      .resolve_ready    (resolve_ready),
      .fifo_branch_addr (fifo_branch_addr),
      .branch_result    (branch_result),
      .update_strobe    (update_strobe),
      .mispredict       (mispredict),
      .overflow         (overflow),
      .underflow        (underflow)
`ifdef BRANCH_RESOLVE_STATS_EN
      ,
      .stat_resolved    (stat_resolved),
      .stat_mispredicted(stat_mispredicted)
`endif
   );

   always #5 clock = ~clock;

   int n_cmp = 0;
   int n_err = 0;
   bit chk_en = 1'b0;

   // Reference model: pending branches in order, plus a countdown of the
   // update handshake (2 = address/result cycle, 1 = strobe cycle, 0 = ready)
   br_entry_t         mq[$];
   int                m_busy;
   logic              m_mis, m_ovf, m_unf, m_res;
   logic [ADDR_W-1:0] m_addr;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      mq.delete();
      m_busy = 0;
      m_mis  = 0;
      m_ovf  = 0;
      m_unf  = 0;
      m_res  = 0;
      m_addr = '0;
`ifdef BRANCH_RESOLVE_STATS_EN
      m_sres = 0;
      m_smis = 0;
`endif
   endtask

   task automatic model_step();
      bit        was_full;
      bit        acc, pop, mis;
      br_entry_t h;
      was_full = (mq.size() == DEPTH);
      acc      = resolve_valid && (m_busy == 0);
      pop      = acc && (mq.size() != 0);
      mis      = 0;
      if (m_busy > 0) m_busy--;
      m_mis = 0;
      if (acc && !pop) m_unf = 1;
      if (pop) begin
         h      = mq.pop_front();
         m_addr = h.addr;
         m_res  = resolve_taken;
         mis    = (h.pred != resolve_taken);
         m_mis  = mis;
         m_busy = 2;
`ifdef BRANCH_RESOLVE_STATS_EN
         if (m_sres < 16'hFFFF) m_sres++;
         if (mis && m_smis < 16'hFFFF) m_smis++;
`endif
      end
      if (mis) mq.delete();
      else if (push) begin
         if (!was_full || pop) mq.push_back('{addr: push_addr, pred: push_pred});
         else m_ovf = 1;
      end
   endtask

   // Continuous comparison against the model, away from the active edge
   always @(negedge clock) begin
      if (chk_en && !reset) begin
         chk("count", 32'(count), 32'(mq.size()));
         chk("empty", 32'(empty), 32'(mq.size() == 0));
         chk("full", 32'(full), 32'(mq.size() == DEPTH));
         chk("ready", 32'(resolve_ready), 32'(m_busy == 0));
         chk("strobe", 32'(update_strobe), 32'(m_busy == 1));
         chk("mispredict", 32'(mispredict), 32'(m_mis));
         chk("overflow", 32'(overflow), 32'(m_ovf));
         chk("underflow", 32'(underflow), 32'(m_unf));
         chk("addr", 32'(fifo_branch_addr), 32'(m_addr));
         chk("result", 32'(branch_result), 32'(m_res));
`ifdef BRANCH_RESOLVE_STATS_EN
         chk("stat_resolved", 32'(stat_resolved), 32'(m_sres));
         chk("stat_mispredicted", 32'(stat_mispredicted), 32'(m_smis));
`endif
      end
   end

   // One clock: drive inputs, take the edge, advance the model, settle
   task automatic cyc(input logic p, input logic [ADDR_W-1:0] pa, input logic pp,
                      input logic rv, input logic rt);
      push          = p;
      push_addr     = pa;
      push_pred     = pp;
      resolve_valid = rv;
      resolve_taken = rt;
      @(posedge clock);
      model_step();
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(0, '0, 0, 0, 0);
   endtask

   task automatic do_reset();
      cyc_inputs_zero();
      reset = 1'b1;
      model_reset();
      repeat (2) @(posedge clock);
      #1 reset = 1'b0;
   endtask

   task automatic cyc_inputs_zero();
      push          = 0;
      push_addr     = '0;
      push_pred     = 0;
      resolve_valid = 0;
      resolve_taken = 0;
   endtask

   int st_idx[$];
   int n_strobe;

   initial begin
      cyc_inputs_zero();
      do_reset();
      // Reset values
      chk("rst_count", 32'(count), 32'd0);
      chk("rst_empty", 32'(empty), 32'd1);
      chk("rst_ready", 32'(resolve_ready), 32'd1);
      chk("rst_strobe", 32'(update_strobe), 32'd0);
      chk_en = 1'b1;

      // Single correct resolution
      cyc(1, 11'h123, 1, 0, 0);
      cyc(0, '0, 0, 1, 1);
      chk("t1_addr", 32'(fifo_branch_addr), 32'h123);
      chk("t1_result", 32'(branch_result), 32'd1);
      chk("t1_mis", 32'(mispredict), 32'd0);
      chk("t1_strobe_setup", 32'(update_strobe), 32'd0);
      chk("t1_count", 32'(count), 32'd0);
      idle(1);
      chk("t1_strobe", 32'(update_strobe), 32'd1);
      idle(1);
      chk("t1_strobe_done", 32'(update_strobe), 32'd0);
      chk("t1_ready", 32'(resolve_ready), 32'd1);

      // Mispredict flushes younger entries, then an empty resolve underflows
      cyc(1, 11'h010, 1, 0, 0);
      cyc(1, 11'h020, 0, 0, 0);
      cyc(1, 11'h030, 1, 0, 0);
      cyc(0, '0, 0, 1, 0);
      chk("t2_mis", 32'(mispredict), 32'd1);
      chk("t2_addr", 32'(fifo_branch_addr), 32'h010);
      chk("t2_count", 32'(count), 32'd0);
      idle(1);
      chk("t2_mis_gone", 32'(mispredict), 32'd0);
      idle(1);
      cyc(0, '0, 0, 1, 1);
      chk("t2_underflow", 32'(underflow), 32'd1);
      chk("t2_no_strobe_ready", 32'(resolve_ready), 32'd1);

      // Fill, overflow, then push plus correct pop while full
      do_reset();
      for (int i = 0; i < DEPTH; i++) cyc(1, ADDR_W'(11'h040 + i), 1, 0, 0);
      cyc(1, 11'h7FF, 1, 0, 0);
      chk("t3_full", 32'(full), 32'd1);
      chk("t3_overflow", 32'(overflow), 32'd1);
      chk("t3_count", 32'(count), 32'd8);
      cyc(1, 11'h050, 1, 1, 1);
      chk("t3_count_hold", 32'(count), 32'd8);
      chk("t3_addr", 32'(fifo_branch_addr), 32'h040);
      idle(2);

      // Back-to-back resolutions with resolve_valid held high
      do_reset();
      for (int i = 0; i < 4; i++) cyc(1, ADDR_W'(11'h100 + i), 0, 0, 0);
      st_idx.delete();
      for (int i = 0; i < 14; i++) begin
         cyc(0, '0, 0, 1, 0);
         if (update_strobe) begin
            chk("t4_addr", 32'(fifo_branch_addr), 32'h100 + 32'(st_idx.size()));
            st_idx.push_back(i);
         end
      end
      n_strobe = st_idx.size();
      chk("t4_nstrobe", 32'(n_strobe), 32'd4);
      for (int k = 1; k < st_idx.size(); k++)
         chk("t4_spacing", 32'(st_idx[k] - st_idx[k-1]), 32'd3);

      // Reset asserted while the strobe is high
      do_reset();
      cyc(1, 11'h2AA, 0, 0, 0);
      cyc(0, '0, 0, 1, 0);
      idle(1);
      chk("t5_strobe_before", 32'(update_strobe), 32'd1);
      #2 reset = 1'b1;
      #1;
      chk("t5_strobe_async", 32'(update_strobe), 32'd0);
      chk("t5_count", 32'(count), 32'd0);
      chk("t5_ready", 32'(resolve_ready), 32'd1);
      model_reset();
      reset = 1'b0;
      idle(2);

`ifdef BRANCH_RESOLVE_STATS_EN
      // Three correct and two mispredicted resolutions
      do_reset();
      for (int k = 0; k < 5; k++) begin
         cyc(1, ADDR_W'(11'h200 + k), 1, 0, 0);
         cyc(0, '0, 0, 1, (k < 3) ? 1'b1 : 1'b0);
         idle(2);
      end
      chk("stats_resolved", 32'(stat_resolved), 32'd5);
      chk("stats_mispredicted", 32'(stat_mispredicted), 32'd2);
`endif

      // Randomized traffic
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         logic p, pp, rv, rt;
         p  = ($urandom_range(0, 9) < 6);
         pp = 1'($urandom_range(0, 1));
         rv = ($urandom_range(0, 9) < 4);
         if (mq.size() != 0 && $urandom_range(0, 9) < 8) rt = mq[0].pred;
         else rt = 1'($urandom_range(0, 1));
         cyc(p, ADDR_W'($urandom_range(0, 2047)), pp, rv, rt);
      end
      idle(3);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
